// File: rtl/layer_ram_arbiter_pkg.sv
// Shared layer-RAM types: arbiter state and grant encodings, plus default access timings.
// Also used by the layer RAM sequencing logic, so keep encodings stable.
package layer_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD     = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_WR     = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_CTRL = 1'b0,
    GRANT_PIPE = 1'b1
  } grant_t;

  localparam int WRITE_CYCLES_DEFAULT = 6;
  localparam int READ_CYCLES_DEFAULT  = 1;
  localparam int CYCLE_CNT_W          = 5;

  // Terminal value of the per-access cycle counter, which counts 0..cycles-1.
  function automatic logic [CYCLE_CNT_W-1:0] last_count(input int cycles);
    return CYCLE_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/layer_ram_rr_pick.sv
// Two-way controller/pipeline pick: controller preferred, pipeline wins a tie right after a controller grant.
// Purely combinational; no state, the caller owns lastGrant.
module layer_ram_rr_pick
  import layer_ram_arbiter_pkg::*;
(
  input  logic   ctrl_req,
  input  logic   pipe_req,
  input  grant_t last_grant,
  output logic   grant_vld,
  output grant_t grant
);

  always_comb begin
    grant_vld = ctrl_req | pipe_req;
    grant     = GRANT_CTRL;
    if (pipe_req && (!ctrl_req || last_grant == GRANT_CTRL)) begin
      grant = GRANT_PIPE;
    end
  end

endmodule

// File: rtl/layer_ram_arbiter.sv
// Shares one single-port layer RAM between the controller (read/write) and the pipeline (read only).
// Ack is same-cycle in IDLE; reads return READ_CYCLES+1 cycles after ack; losers simply hold req.
module layer_ram_arbiter
  import layer_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int WRITE_CYCLES = WRITE_CYCLES_DEFAULT,
  parameter int READ_CYCLES  = READ_CYCLES_DEFAULT
) (
  input  logic              gpuClock,
  input  logic              reset,
  input  logic              ctrlReq,
  input  logic              ctrlWe,
  input  logic [ADDR_W-1:0] ctrlAddr,
  input  logic [DATA_W-1:0] ctrlWdata,
  output logic              ctrlAck,
  output logic              ctrlRvalid,
  output logic [DATA_W-1:0] ctrlRdata,
  output logic              ctrlWdone,
  input  logic              pipeReq,
  input  logic [ADDR_W-1:0] pipeAddr,
  output logic              pipeAck,
  output logic              pipeRvalid,
  output logic [DATA_W-1:0] pipeRdata,
  output logic              ramCe,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata,
  output logic              busy
);

  localparam logic [CYCLE_CNT_W-1:0] WR_LAST = last_count(WRITE_CYCLES);
  localparam logic [CYCLE_CNT_W-1:0] RD_LAST = last_count(READ_CYCLES);
  localparam logic [CYCLE_CNT_W-1:0] CNT_ONE = CYCLE_CNT_W'(1);

  arb_state_t             state;
  grant_t                 last_grant;
  grant_t                 owner;
  logic [CYCLE_CNT_W-1:0] cnt;
  logic                   grant_vld;
  grant_t                 grant;
  logic                   arb_en;

  layer_ram_rr_pick u_pick (
    .ctrl_req   (ctrlReq),
    .pipe_req   (pipeReq),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  // Acks are masked during reset so a held request cannot be acked before arbitration starts.
  assign arb_en  = reset && (state == ST_IDLE) && grant_vld;
  assign ctrlAck = arb_en && (grant == GRANT_CTRL);
  assign pipeAck = arb_en && (grant == GRANT_PIPE);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_PIPE;
      owner      <= GRANT_PIPE;
      cnt        <= '0;
      ramCe      <= 1'b0;
      ramWe      <= 1'b0;
      ramAddr    <= '0;
      ramWdata   <= '0;
      ctrlRdata  <= '0;
      pipeRdata  <= '0;
      ctrlRvalid <= 1'b0;
      pipeRvalid <= 1'b0;
      ctrlWdone  <= 1'b0;
    end else begin
      ctrlRvalid <= 1'b0;
      pipeRvalid <= 1'b0;
      ctrlWdone  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            last_grant <= grant;
            owner      <= grant;
            cnt        <= '0;
            ramCe      <= 1'b1;
            if (grant == GRANT_CTRL) begin
              ramAddr  <= ctrlAddr;
              ramWdata <= ctrlWdata;
            end else begin
              ramAddr  <= pipeAddr;
            end
            if (grant == GRANT_CTRL && ctrlWe) begin
              state     <= ST_WR;
              ramWe     <= 1'b1;
              ctrlWdone <= (WR_LAST == '0);
            end else begin
              state     <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (cnt == RD_LAST) begin
            state <= ST_RD_CAP;
            ramCe <= 1'b0;
            if (owner == GRANT_CTRL) begin
              ctrlRdata  <= ramRdata;
              ctrlRvalid <= 1'b1;
            end else begin
              pipeRdata  <= ramRdata;
              pipeRvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_RD_CAP: begin
          state <= ST_IDLE;
        end
        ST_WR: begin
          // Done pulse is registered one cycle ahead so it lands in the final write cycle.
          if (cnt == WR_LAST) begin
            state <= ST_IDLE;
            ramCe <= 1'b0;
            ramWe <= 1'b0;
          end else begin
            cnt       <= cnt + CNT_ONE;
            ctrlWdone <= ((cnt + CNT_ONE) == WR_LAST);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_ram_arbiter.sv
// Bench for layer_ram_arbiter: RAM model, read-data scoreboard and one task per scenario.
module tb_layer_ram_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  logic              gpuClock = 1'b0;
  logic              reset;
  logic              ctrlReq, ctrlWe;
  logic [ADDR_W-1:0] ctrlAddr;
  logic [DATA_W-1:0] ctrlWdata;
  logic              ctrlAck, ctrlRvalid, ctrlWdone;
  logic [DATA_W-1:0] ctrlRdata;
  logic              pipeReq;
  logic [ADDR_W-1:0] pipeAddr;
  logic              pipeAck, pipeRvalid;
  logic [DATA_W-1:0] pipeRdata;
  logic              ramCe, ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata;
  logic [DATA_W-1:0] ramRdata = '0;
  logic              busy;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_ctrl[$];
  logic [DATA_W-1:0] exp_pipe[$];
  logic [DATA_W-1:0] sb_exp;
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  layer_ram_arbiter dut (
    .gpuClock   (gpuClock),
    .reset      (reset),
    .ctrlReq    (ctrlReq),
    .ctrlWe     (ctrlWe),
    .ctrlAddr   (ctrlAddr),
    .ctrlWdata  (ctrlWdata),
    .ctrlAck    (ctrlAck),
    .ctrlRvalid (ctrlRvalid),
    .ctrlRdata  (ctrlRdata),
    .ctrlWdone  (ctrlWdone),
    .pipeReq    (pipeReq),
    .pipeAddr   (pipeAddr),
    .pipeAck    (pipeAck),
    .pipeRvalid (pipeRvalid),
    .pipeRdata  (pipeRdata),
    .ramCe      (ramCe),
    .ramWe      (ramWe),
    .ramAddr    (ramAddr),
    .ramWdata   (ramWdata),
    .ramRdata   (ramRdata),
    .busy       (busy)
  );

  always #5 gpuClock = ~gpuClock;

  function automatic logic [DATA_W-1:0] ram_lookup(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[DATA_W-1:0] ^ 16'h5A5A;
  endfunction

  // RAM model: writes commit on the clock edge, read data appears mid-cycle for capture at the next edge.
  always @(posedge gpuClock) if (ramCe && ramWe) mem[ramAddr] = ramWdata;
  always @(negedge gpuClock) ramRdata = (ramCe && !ramWe) ? ram_lookup(ramAddr) : '0;

  always @(negedge gpuClock) begin
    if (pipeRvalid === 1'b1) begin
      total++;
      if (exp_pipe.size() == 0) begin
        bad++;
        $display("FAIL pipe_sb: unexpected pipeRvalid data=%h want none", pipeRdata);
      end else begin
        sb_exp = exp_pipe.pop_front();
        if (pipeRdata !== sb_exp) begin
          bad++;
          $display("FAIL pipe_sb: got %h want %h", pipeRdata, sb_exp);
        end
      end
    end
    if (ctrlRvalid === 1'b1) begin
      total++;
      if (exp_ctrl.size() == 0) begin
        bad++;
        $display("FAIL ctrl_sb: unexpected ctrlRvalid data=%h want none", ctrlRdata);
      end else begin
        sb_exp = exp_ctrl.pop_front();
        if (ctrlRdata !== sb_exp) begin
          bad++;
          $display("FAIL ctrl_sb: got %h want %h", ctrlRdata, sb_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge gpuClock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ctrlReq = 1'b1; ctrlWe = 1'b0; ctrlAddr = 18'h00123; ctrlWdata = '0;
    pipeReq = 1'b1; pipeAddr = 18'h00456;
    repeat (2) @(posedge gpuClock);
    @(negedge gpuClock);
    total++;
    if ({busy, ramCe, ramWe, ctrlAck, pipeAck, ctrlRvalid, pipeRvalid, ctrlWdone} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000000",
               {busy, ramCe, ramWe, ctrlAck, pipeAck, ctrlRvalid, pipeRvalid, ctrlWdone});
    end
    total++;
    if (ramAddr !== '0 || ramWdata !== '0) begin
      bad++;
      $display("FAIL reset_ram: got addr=%h wdata=%h want 0/0", ramAddr, ramWdata);
    end
    total++;
    if (ctrlRdata !== '0 || pipeRdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata: got ctrl=%h pipe=%h want 0/0", ctrlRdata, pipeRdata);
    end
    ctrlReq = 1'b0; pipeReq = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_pipe_read();
    tick(); pipeReq = 1'b1; pipeAddr = 18'h00010;
    @(negedge gpuClock);
    total++;
    if (pipeAck !== 1'b1 || ctrlAck !== 1'b0) begin
      bad++; $display("FAIL pipe_ack: got pipe=%b ctrl=%b want 1/0", pipeAck, ctrlAck);
    end
    exp_pipe.push_back(16'hBEEF);
    tick(); pipeReq = 1'b0;
    @(negedge gpuClock);
    total++;
    if ({busy, ramCe, ramWe, pipeRvalid} !== 4'b1100 || ramAddr !== 18'h00010) begin
      bad++; $display("FAIL pipe_rd_cyc1: got %b addr=%h want 1100 addr=00010",
                      {busy, ramCe, ramWe, pipeRvalid}, ramAddr);
    end
    tick(); @(negedge gpuClock);
    total++;
    if (pipeRvalid !== 1'b1) begin
      bad++; $display("FAIL pipe_rvalid_cyc2: got %b want 1", pipeRvalid);
    end
    tick(); @(negedge gpuClock);
    total++;
    if ({busy, pipeRvalid, ctrlRvalid} !== 3'b000 || pipeRdata !== 16'hBEEF) begin
      bad++; $display("FAIL pipe_hold: got %b data=%h want 000 data=beef",
                      {busy, pipeRvalid, ctrlRvalid}, pipeRdata);
    end
  endtask

  task automatic test_ctrl_write();
    int we_cnt = 0, first_we = -1, done_at = -1, done_cnt = 0;
    bit stable = 1'b1;
    tick(); ctrlReq = 1'b1; ctrlWe = 1'b1; ctrlAddr = 18'h3FFFF; ctrlWdata = 16'h1234;
    @(negedge gpuClock);
    total++;
    if (ctrlAck !== 1'b1 || pipeAck !== 1'b0) begin
      bad++; $display("FAIL wr_ack: got ctrl=%b pipe=%b want 1/0", ctrlAck, pipeAck);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin ctrlReq = 1'b0; ctrlWe = 1'b0; ctrlAddr = '0; ctrlWdata = '0; end
      @(negedge gpuClock);
      if (ramWe === 1'b1) begin
        we_cnt++;
        if (first_we < 0) first_we = c;
        if (ramAddr !== 18'h3FFFF || ramWdata !== 16'h1234 || ramCe !== 1'b1) stable = 1'b0;
      end
      if (ctrlWdone === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    total++;
    if (we_cnt != 6 || first_we != 1) begin
      bad++; $display("FAIL wr_len: got %0d cycles from %0d want 6 from 1", we_cnt, first_we);
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL wr_stable: got unstable addr/data/ce want stable 3ffff/1234");
    end
    total++;
    if (done_at != 6 || done_cnt != 1) begin
      bad++; $display("FAIL wr_done: got cycle %0d count %0d want cycle 6 count 1", done_at, done_cnt);
    end
  endtask

  task automatic test_ctrl_read();
    int rv_at = -1;
    tick(); ctrlReq = 1'b1; ctrlWe = 1'b0; ctrlAddr = 18'h3FFFF;
    @(negedge gpuClock);
    total++;
    if (ctrlAck !== 1'b1) begin
      bad++; $display("FAIL rd_ack: got %b want 1", ctrlAck);
    end
    exp_ctrl.push_back(16'h1234);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) ctrlReq = 1'b0;
      @(negedge gpuClock);
      if (ctrlRvalid === 1'b1 && rv_at < 0) rv_at = c;
    end
    total++;
    if (rv_at != 2) begin
      bad++; $display("FAIL rd_latency: got %0d want 2", rv_at);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] seq = '0;
    int n = 0, nc = 0, np = 0, both = 0, first_ack = -1;
    reset = 1'b0;
    ctrlReq = 1'b1; ctrlWe = 1'b0; ctrlAddr = 18'h00400;
    pipeReq = 1'b1; pipeAddr = 18'h00800;
    repeat (2) @(posedge gpuClock);
    #1 reset = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) tick();
      @(negedge gpuClock);
      if (ctrlAck === 1'b1 && pipeAck === 1'b1) both++;
      if (ctrlAck === 1'b1) begin
        exp_ctrl.push_back(ram_lookup(ctrlAddr));
        seq[n] = 1'b1; n++; nc++;
        if (first_ack < 0) first_ack = c;
      end else if (pipeAck === 1'b1) begin
        exp_pipe.push_back(ram_lookup(pipeAddr));
        seq[n] = 1'b0; n++; np++;
        if (first_ack < 0) first_ack = c;
      end
    end
    tick(); ctrlReq = 1'b0; pipeReq = 1'b0;
    repeat (5) tick();
    total++;
    if (first_ack != 0) begin
      bad++; $display("FAIL alt_first: got cycle %0d want 0", first_ack);
    end
    total++;
    if (seq[3:0] !== 4'b0101) begin
      bad++; $display("FAIL alt_order: got %b want 0101 (bit0 first, 1=ctrl)", seq[3:0]);
    end
    total++;
    if (n != 5 || nc < 2 || np < 2 || both != 0) begin
      bad++; $display("FAIL alt_fair: got n=%0d ctrl=%0d pipe=%0d both=%0d want 5 >=2 >=2 0",
                      n, nc, np, both);
    end
  endtask

  task automatic test_wait_during_wr();
    int done_at = -1, pack_at = -1;
    tick(); ctrlReq = 1'b1; ctrlWe = 1'b1; ctrlAddr = 18'h00100; ctrlWdata = 16'hCAFE;
    @(negedge gpuClock);
    total++;
    if (ctrlAck !== 1'b1) begin
      bad++; $display("FAIL wait_ack: got %b want 1", ctrlAck);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin ctrlReq = 1'b0; ctrlWe = 1'b0; end
      if (c == 3) begin pipeReq = 1'b1; pipeAddr = 18'h00100; end
      if (pack_at >= 0) pipeReq = 1'b0;
      @(negedge gpuClock);
      if (ctrlWdone === 1'b1 && done_at < 0) done_at = c;
      if (pipeAck === 1'b1 && pack_at < 0) begin
        pack_at = c;
        exp_pipe.push_back(16'hCAFE);
      end
    end
    total++;
    if (done_at != 6 || pack_at != 7) begin
      bad++; $display("FAIL wait_grant: got done=%0d ack=%0d want 6/7", done_at, pack_at);
    end
  endtask

  task automatic test_reset_mid_write();
    int wd = 0, stuck = 0;
    tick(); ctrlReq = 1'b1; ctrlWe = 1'b1; ctrlAddr = 18'h00200; ctrlWdata = 16'h7777;
    tick(); ctrlReq = 1'b0; ctrlWe = 1'b0;
    tick(); tick(); tick();
    @(negedge gpuClock);
    total++;
    if (ramWe !== 1'b1) begin
      bad++; $display("FAIL rst_pre: got ramWe=%b want 1", ramWe);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({ramWe, ramCe, busy, ctrlWdone} !== 4'b0000) begin
      bad++; $display("FAIL rst_async: got %b want 0000", {ramWe, ramCe, busy, ctrlWdone});
    end
    repeat (3) begin
      @(negedge gpuClock);
      if (ctrlWdone === 1'b1) wd++;
    end
    @(posedge gpuClock); #1 reset = 1'b1;
    repeat (8) begin
      tick(); @(negedge gpuClock);
      if (ctrlWdone === 1'b1) wd++;
      if (busy === 1'b1 || ramWe === 1'b1) stuck++;
    end
    total++;
    if (wd != 0 || stuck != 0) begin
      bad++; $display("FAIL rst_after: got wdone=%0d busy_cycles=%0d want 0/0", wd, stuck);
    end
  endtask

  task automatic test_ignored_pulse();
    int cack = 0, we = 0, ce = 0;
    tick(); pipeReq = 1'b1; pipeAddr = 18'h00010;
    @(negedge gpuClock);
    total++;
    if (pipeAck !== 1'b1) begin
      bad++; $display("FAIL pulse_pipe_ack: got %b want 1", pipeAck);
    end
    exp_pipe.push_back(16'hBEEF);
    tick(); pipeReq = 1'b0; ctrlReq = 1'b1; ctrlWe = 1'b1; ctrlAddr = 18'h00055; ctrlWdata = 16'h9999;
    @(negedge gpuClock);
    if (ctrlAck === 1'b1) cack++;
    if (ramCe === 1'b1) ce++;
    if (ramWe === 1'b1) we++;
    tick(); ctrlReq = 1'b0; ctrlWe = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge gpuClock);
      if (ctrlAck === 1'b1) cack++;
      if (ramCe === 1'b1) ce++;
      if (ramWe === 1'b1) we++;
      tick();
    end
    total++;
    if (cack != 0 || we != 0 || ce != 1) begin
      bad++; $display("FAIL pulse_ignored: got ack=%0d we=%0d ce=%0d want 0/0/1", cack, we, ce);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem[18'h00010] = 16'hBEEF;
    test_reset();
    test_pipe_read();
    test_ctrl_write();
    test_ctrl_read();
    test_alternate();
    test_wait_during_wr();
    test_reset_mid_write();
    test_ignored_pulse();
    repeat (4) tick();
    total++;
    if (exp_pipe.size() != 0 || exp_ctrl.size() != 0) begin
      bad++; $display("FAIL sb_drain: got pipe=%0d ctrl=%0d pending want 0/0",
                      exp_pipe.size(), exp_ctrl.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_ram_arbiter.md
LAYER_RAM_ARBITER -- requirements
Module: layer_ram_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 18, RAM word address width; DATA_W, default 16, RAM word width; WRITE_CYCLES, default 6, ramWe hold length in gpuClock cycles; READ_CYCLES, default 1, cycles from address to valid ramRdata.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: gpuClock  in  1  400 MHz GPU clock; reset  in  1  async active-low reset.
REQ-003 ctrlReq  in  1  controller access request, held until ctrlAck.
REQ-004 ctrlWe  in  1  1 = write, 0 = read; qualified by ctrlReq.
REQ-005 ctrlAddr  in  ADDR_W  controller address; ctrlWdata  in  DATA_W  controller write data.
REQ-006 ctrlAck  out  1  one-cycle pulse, request accepted; ctrlRvalid  out  1  one-cycle pulse, ctrlRdata valid; ctrlRdata  out  DATA_W  read data; ctrlWdone  out  1  one-cycle pulse, write finished.
REQ-007 pipeReq  in  1  pipeline read request, held until pipeAck; pipeAddr  in  ADDR_W  pipeline address.
REQ-008 pipeAck  out  1  accept pulse; pipeRvalid  out  1  data-valid pulse; pipeRdata  out  DATA_W  read data.
REQ-009 ramCe  out  1  RAM enable; ramWe  out  1  RAM write enable; ramAddr  out  ADDR_W; ramWdata  out  DATA_W; ramRdata  in  DATA_W.
REQ-010 busy  out  1  high in every state except IDLE.

Function
REQ-011 FSM states: IDLE, RD, RD_CAP, WR.
REQ-012 IDLE arbitration: a controller request wins unless lastGrant = CTRL and pipeReq = 1, in which case the pipeline wins; a lone request always wins.
REQ-013 On a grant, the block SHALL pulse the winner's ack in the same cycle and register addr, data and we into ramAddr, ramWdata and the op latch; next state is RD (read) or WR (write); lastGrant updates.
REQ-014 RD: ramCe = 1, ramWe = 0 for READ_CYCLES cycles, then RD_CAP.
REQ-015 RD_CAP: register ramRdata into the owner's rdata; pulse the owner's rvalid for one cycle; return to IDLE.
REQ-016 Read latency: ack to rvalid = READ_CYCLES + 1 cycles; with the default, a back-to-back grant is possible every 3 cycles.
REQ-017 WR: ramCe = ramWe = 1; ramAddr and ramWdata stable for exactly WRITE_CYCLES cycles, counted 0..WRITE_CYCLES-1 by a 5-bit counter; ctrlWdone pulses in the last WR cycle; next state IDLE.
REQ-018 Requests arriving outside IDLE SHALL wait; no request is dropped while its req is held.
REQ-019 A req deasserted before its ack SHALL be ignored.
REQ-020 Rdata outputs SHALL hold their last value between rvalid pulses.
REQ-021 The pipeline SHALL never receive ctrlRvalid or ctrlWdone, and the controller SHALL never receive pipeRvalid.
REQ-022 ramCe = 0 and ramWe = 0 in IDLE.

Reset
REQ-023 Asserting reset SHALL asynchronously force: state IDLE, all acks, rvalids, ctrlWdone, ramCe, ramWe and busy to 0; ramAddr, ramWdata, rdata outputs and the counter to 0; lastGrant = PIPE.
REQ-024 Reset mid-write SHALL drop ramWe immediately with no ctrlWdone.
REQ-025 After reset release, the first arbitration SHALL occur on the first gpuClock rising edge.

Structure
REQ-026 The state encoding, lastGrant encoding and the WRITE_CYCLES and READ_CYCLES defaults SHALL live in a shared gpu package, also used by the layer RAM sequencing logic.
REQ-027 One sub-module, layer_ram_rr_pick, SHALL implement the two-way priority/fairness pick of REQ-012.

Verification
REQ-028 Lone pipe read: pipeReq with addr 0x00010, RAM returning 0xBEEF -> pipeAck in cycle 0, pipeRvalid with 0xBEEF in cycle 2.
REQ-029 Controller write: addr 0x3FFFF, data 0x1234 -> ctrlAck; ramWe high for exactly 6 cycles with stable addr and data; ctrlWdone in the 6th cycle.
REQ-030 Simultaneous ctrlReq (read) and pipeReq held continuously from reset -> grants alternate PIPE?, no: CTRL, PIPE, CTRL, PIPE, since lastGrant = PIPE after reset; neither requester starves.
REQ-031 pipeReq arriving during WR cycle 2 -> granted in the first IDLE cycle after ctrlWdone.
REQ-032 Reset asserted during WR cycle 3 -> ramWe = 0 asynchronously; no ctrlWdone; IDLE after release.
REQ-033 ctrlReq pulsed for one cycle during RD -> never acked, no RAM access.
